car_sensor_gen: RTL and testbench
=================================

# car_sensor_gen

Drives the two parking-barrier sensor lines A and B with the exact two-beam sequence that a car produces while crossing. It is the transmit-side counterpart of the A/B sensor decoder: one accepted request produces one complete entry or exit crossing on {A,B}. It is used as a stimulus source for FPGA bring-up and loopback self-test, where its outputs feed the decoder's A/B inputs.

## Interface
- STEP_CYCLES, 4: cycles each intermediate {A,B} code is held; legal range 1..65535.
- GAP_CYCLES, 2: cycles {A,B}=00 is held after a crossing before the next request can be accepted; legal range 1..65535.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  crossing request.
- req_dir  in  1  0 = entry, 1 = exit; sampled on acceptance.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- A  out  1  sensor A, registered.
- B  out  1  sensor B, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when {A,B} returns to 00 at the end of a crossing.

## Operation
- States: IDLE, PH1, PH2, PH3, GAP.
- Crossing codes, {A,B}:
  - Entry: PH1=10, PH2=11, PH3=01, then 00.
  - Exit: PH1=01, PH2=11, PH3=10, then 00.
- Transitions:
  - IDLE→PH1 on acceptance. req_dir is latched into a direction register at this edge.
  - PH1→PH2→PH3 each after STEP_CYCLES cycles in the state.
  - PH3→GAP after STEP_CYCLES cycles; {A,B}=00 and done=1 for that first GAP cycle.
  - GAP→IDLE after GAP_CYCLES cycles.
- Dwell counter: 16 bits, loaded with STEP_CYCLES-1 or GAP_CYCLES-1 on state entry, decremented each cycle. The state advances when the counter is 0. No wrap-around is possible.
- req_valid, req_dir and any change on them while busy are ignored; there is no queuing.
- Only Gray-adjacent codes are ever emitted; A and B never change in the same cycle.

## Timing
- Reset values: A=0, B=0, done=0, busy=0, req_ready=1, state IDLE, direction 0, counter 0.
- Reset asserted mid-crossing forces {A,B}=00 asynchronously and aborts the crossing without a done pulse.
- Example, acceptance at edge 0 with STEP=4, GAP=2:
  - PH1 code in cycles 1-4, PH2 in cycles 5-8, PH3 in cycles 9-12.
  - 00 with done=1 in cycle 13.
  - req_ready=1 again in cycle 15.
- General timing: done occurs 3·STEP_CYCLES+1 cycles after acceptance. The next acceptance is possible 3·STEP_CYCLES+GAP_CYCLES+1 cycles after acceptance.
- Back-to-back operation: a request held high continuously is accepted on the first IDLE edge; {A,B} stays 00 for exactly GAP_CYCLES+1 cycles between crossings.

## Configuration
- CAR_GEN_OCC_EN defined:
  - Adds output occ (8 bits, reset 0) and output err (1 bit, one-cycle pulse, reset 0).
  - occ increments in the done cycle of an entry and decrements in the done cycle of an exit.
  - An exit accepted while occ==0, or an entry accepted while occ==255, is discarded. err=1 in the cycle after acceptance, {A,B} stays 00, there is no done pulse, and the block returns to IDLE, so req_ready=1 in that same cycle.
- CAR_GEN_OCC_EN undefined: no occ or err ports, and every accepted request produces a crossing.

## Test plan
- Reset, then a single entry with STEP=4, GAP=2 accepted at edge 0 → {A,B}=10,11,01 for 4 cycles each from cycle 1, 00 with done in cycle 13, req_ready high in cycle 15.
- Single exit → {A,B}=01,11,10, then 00; when looped into the sensor decoder, its exit output pulses exactly once and its entry output never does.
- Continuous req_valid alternating direction for 4 crossings → 00 gap of exactly 3 cycles between crossings; A and B never toggle in the same cycle.
- req_valid pulsed while busy → ignored, with no change to the sequence or its timing.
- rst_n low in cycle 6 of an entry → A=B=0 immediately, no done, req_ready=1 after release.
- With CAR_GEN_OCC_EN: exit first → err in cycle 1, occ=0; then 2 entries and 1 exit → occ=1.

Source files
------------

// File: rtl/car_sensor_gen.sv
// car_sensor_gen: drives the parking-barrier sensor lines {A,B} with the
// two-beam sequence a car produces while crossing. One accepted request
// yields one complete entry (10,11,01,00) or exit (01,11,10,00) crossing.
// Only Gray-adjacent codes are emitted, so A and B never change together.
//
// Handshake: a request is accepted on a rising edge where
// req_valid && req_ready; req_ready is high only in IDLE, and
// req_valid/req_dir are ignored at all other times (no queuing).
//
// Optional feature, enabled by defining CAR_GEN_OCC_EN: adds an 8-bit
// occupancy count (occ) and a one-cycle err pulse for requests that would
// under/overflow it; such requests are discarded without a crossing.
module car_sensor_gen #(
    parameter int STEP_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_dir,
    output logic       req_ready,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done
`ifdef CAR_GEN_OCC_EN
    ,
    output logic [7:0] occ,
    output logic       err
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PH1  = 3'd1;
    localparam logic [2:0] S_PH2  = 3'd2;
    localparam logic [2:0] S_PH3  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    // Dwell counter reload values: the counter counts down to 0, so a state
    // lasts exactly STEP_CYCLES (or GAP_CYCLES) cycles.
    localparam logic [15:0] STEP_LOAD = 16'(STEP_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

    // {A,B} codes; entry and exit share the 11 middle phase.
    localparam logic [1:0] CODE_A_ONLY = 2'b10;
    localparam logic [1:0] CODE_BOTH   = 2'b11;
    localparam logic [1:0] CODE_B_ONLY = 2'b01;
    localparam logic [1:0] CODE_NONE   = 2'b00;

    logic [2:0]  state;
    logic        dir;       // 0 = entry, 1 = exit, latched on acceptance
    logic [15:0] cnt;
    logic        accept;
    logic        discard;
    logic        cnt_zero;

    // Handshake and status decode straight from the registered state.
    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        accept    = req_valid && (state == S_IDLE);
        cnt_zero  = (cnt == 16'd0);
`ifdef CAR_GEN_OCC_EN
        // An exit with nobody inside, or an entry into a full count, is refused.
        discard   = (req_dir && (occ == 8'd0)) || (!req_dir && (occ == 8'hFF));
`else
        discard   = 1'b0;
`endif
    end

    // Crossing sequencer: state, dwell counter, registered {A,B} and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            dir   <= 1'b0;
            cnt   <= 16'd0;
            A     <= 1'b0;
            B     <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dir <= req_dir;
                        if (!discard) begin
                            state  <= S_PH1;
                            cnt    <= STEP_LOAD;
                            {A, B} <= req_dir ? CODE_B_ONLY : CODE_A_ONLY;
                        end
                    end
                end
                S_PH1: begin
                    if (cnt_zero) begin
                        state  <= S_PH2;
                        cnt    <= STEP_LOAD;
                        {A, B} <= CODE_BOTH;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_PH2: begin
                    if (cnt_zero) begin
                        state  <= S_PH3;
                        cnt    <= STEP_LOAD;
                        {A, B} <= dir ? CODE_A_ONLY : CODE_B_ONLY;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_PH3: begin
                    if (cnt_zero) begin
                        state  <= S_GAP;
                        cnt    <= GAP_LOAD;
                        {A, B} <= CODE_NONE;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_zero) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    cnt    <= 16'd0;
                    {A, B} <= CODE_NONE;
                end
            endcase
        end
    end

`ifdef CAR_GEN_OCC_EN
    // Occupancy tracking: the count moves on the same edge that raises done,
    // and a refused request raises err for the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= 8'd0;
            err <= 1'b0;
        end else begin
            err <= accept && discard;
            if ((state == S_PH3) && cnt_zero) begin
                if (dir) begin
                    occ <= occ - 8'd1;
                end else begin
                    occ <= occ + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_car_sensor_gen.sv
// tb_car_sensor_gen: bench for car_sensor_gen. A per-cycle expected queue is
// filled from the crossing rules whenever the model sees an acceptance, and
// checked against the DUT on every falling edge; directed runs pin exact
// cycle numbers with literal values.
module tb_car_sensor_gen;

    localparam int STEP = 4;
    localparam int GAP  = 2;
    localparam int XING = 3 * STEP + GAP;   // cycles from acceptance to idle

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_dir = 1'b0;
    logic       req_ready;
    logic       A;
    logic       B;
    logic       busy;
    logic       done;
`ifdef CAR_GEN_OCC_EN
    logic [7:0] occ;
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: one entry per future cycle {dir, ready, busy, a, b, done}.
    logic [5:0] exp_q[$];
    int         n_acc = 0;
    int         m_occ = 0;
    bit         m_err_pend = 0;
    logic [1:0] prev_ab;
    bit         prev_valid = 0;
    bit         gap_mode = 0;
    bit         after_done = 0;
    int         zero_run = 0;
    int         gap_seen = 0;

    car_sensor_gen #(
        .STEP_CYCLES(STEP),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_dir  (req_dir),
        .req_ready(req_ready),
        .A        (A),
        .B        (B),
        .busy     (busy),
`ifdef CAR_GEN_OCC_EN
        .done     (done),
        .occ      (occ),
        .err      (err)
`else
        .done     (done)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected cycles of one crossing, straight from the code table.
    task automatic push_crossing(input logic d);
        logic [1:0] c1;
        logic [1:0] c3;
        c1 = d ? 2'b01 : 2'b10;
        c3 = d ? 2'b10 : 2'b01;
        repeat (STEP) exp_q.push_back({d, 1'b0, 1'b1, c1, 1'b0});
        repeat (STEP) exp_q.push_back({d, 1'b0, 1'b1, 2'b11, 1'b0});
        repeat (STEP) exp_q.push_back({d, 1'b0, 1'b1, c3, 1'b0});
        exp_q.push_back({d, 1'b0, 1'b1, 2'b00, 1'b1});
        repeat (GAP - 1) exp_q.push_back({d, 1'b0, 1'b1, 2'b00, 1'b0});
    endtask

    // Asynchronous reset aborts whatever crossing the model expected.
    always @(negedge rst_n) begin
        exp_q.delete();
        prev_valid = 0;
        after_done = 0;
        m_occ = 0;
        m_err_pend = 0;
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        logic [5:0] e;
        bit         disc;
        if (!rst_n) begin
            check("rst_ab", {A, B}, 2'b00);
            check("rst_ready", req_ready, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            exp_q.delete();
            prev_valid = 0;
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'b0_1_0_00_0;
            check("ready", req_ready, e[4]);
            check("busy", busy, e[3]);
            check("ab", {A, B}, e[2:1]);
            check("done", done, e[0]);
`ifdef CAR_GEN_OCC_EN
            if (e[0]) m_occ = e[5] ? m_occ - 1 : m_occ + 1;
            check("occ", occ, m_occ);
            check("err", err, m_err_pend);
            m_err_pend = 0;
`endif
            if (prev_valid) check("gray", ($countones({A, B} ^ prev_ab) <= 1), 1'b1);
            prev_ab = {A, B};
            prev_valid = 1;
            if (!gap_mode) begin
                after_done = 0;
            end else if (after_done && ({A, B} != 2'b00)) begin
                check("gap_len", zero_run, GAP + 1);
                gap_seen++;
                after_done = 0;
            end else if (after_done) begin
                zero_run++;
            end
            if (gap_mode && done) begin
                after_done = 1;
                zero_run = 1;
            end
            if (e[4] && req_valid) begin
                n_acc++;
                disc = 0;
`ifdef CAR_GEN_OCC_EN
                disc = (req_dir && m_occ == 0) || (!req_dir && m_occ == 255);
`endif
                if (disc) m_err_pend = 1;
                else push_crossing(req_dir);
            end
        end
    end

    // Driver: one request from idle with literal cycle checks; optional
    // random noise on req_valid/req_dir while the crossing is in flight.
    task automatic run_single(input logic d, input logic [1:0] c1, input logic [1:0] c3,
                              input bit noise);
        @(posedge clk);
        #1 req_dir = d;
        req_valid = 1'b1;
        @(posedge clk);                        // edge 0: acceptance
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 1)  check("lit_ph1", {A, B}, c1);
            if (i == 4)  check("lit_ph1_end", {A, B}, c1);
            if (i == 5)  check("lit_ph2", {A, B}, 2'b11);
            if (i == 9)  check("lit_ph3", {A, B}, c3);
            if (i == 12) check("lit_no_early_done", done, 1'b0);
            if (i == 13) check("lit_done", {A, B, done}, 3'b001);
            if (i == 14) check("lit_not_ready", req_ready, 1'b0);
            if (i == 15) check("lit_ready", req_ready, 1'b1);
            @(posedge clk);
            #1;
            if (noise && i < 14) begin
                req_valid = ($urandom_range(0, 1) == 1);
                req_dir   = ($urandom_range(0, 1) == 1);
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Stimulus sequence
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", req_ready, 1'b1);
        check("reset_ab", {A, B}, 2'b00);
        check("reset_busy", busy, 1'b0);

        // Single entry, single exit, then an entry with noise while busy.
        run_single(1'b0, 2'b10, 2'b01, 1'b0);
        run_single(1'b1, 2'b01, 2'b10, 1'b0);
`ifdef CAR_GEN_OCC_EN
        // Exit now valid since occ is 0 after entry+exit? Re-enter first.
        run_single(1'b0, 2'b10, 2'b01, 1'b0);
`endif
        run_single(1'b0, 2'b10, 2'b01, 1'b1);

        // Reset asserted in cycle 6 of an entry.
        @(posedge clk);
        #1 req_dir = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);             // now in cycle 6
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ab", {A, B}, 2'b00);
        check("async_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < XING; i++) begin
            @(negedge clk);
            check("post_rst_no_done", done, 1'b0);
        end
        check("post_rst_ready", req_ready, 1'b1);

        // Back-to-back with alternating direction.
        gap_seen = 0;
        gap_mode = 1;
        req_valid = 1'b1;
        repeat (4 * (XING + 1)) begin
            @(posedge clk);
            #1 req_dir = n_acc[0];
        end
        req_valid = 1'b0;
        repeat (XING + 2) @(posedge clk);
        gap_mode = 0;
        check("gap_count", (gap_seen >= 3), 1'b1);

        // Random traffic.
        repeat (400) begin
            @(posedge clk);
            #1 req_valid = ($urandom_range(0, 3) == 0);
            req_dir = ($urandom_range(0, 1) == 1);
        end
        req_valid = 1'b0;
        repeat (XING + 2) @(posedge clk);

`ifdef CAR_GEN_OCC_EN
        // Occupancy: exit at zero refused, then 2 entries and 1 exit.
        pulse_reset();
        @(posedge clk);
        #1 req_dir = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("occ_err", err, 1'b1);
        check("occ_zero", occ, 8'd0);
        check("occ_err_ready", req_ready, 1'b1);
        check("occ_err_ab", {A, B}, 2'b00);
        run_single(1'b0, 2'b10, 2'b01, 1'b0);
        run_single(1'b0, 2'b10, 2'b01, 1'b0);
        run_single(1'b1, 2'b01, 2'b10, 1'b0);
        @(negedge clk);
        check("occ_one", occ, 8'd1);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
